// File: rtl/fab_bitbang_loader_pkg.sv
// Shared state encoding, default control word and phase-length helper for fab_bitbang_loader.
package fab_bb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_LATCH   = 3'd2;
  localparam state_t ST_PH_DATA = 3'd3;
  localparam state_t ST_PH_RISE = 3'd4;
  localparam state_t ST_PH_CTRL = 3'd5;
  localparam state_t ST_PH_FALL = 3'd6;
  localparam state_t ST_DONE    = 3'd7;

  localparam logic [31:0] CTRL_WORD_DEFAULT = 32'h0000FAB1;

  // The falling phase is twice as long so the fabric sees a wide low gap between bits.
  function automatic int phase_len(input state_t st, input int phase_cyc);
    phase_len = (st == ST_PH_FALL) ? 2 * phase_cyc : phase_cyc;
  endfunction

endpackage

// File: rtl/fab_bitbang_loader_if.sv
// Word-wide bitstream memory read port used by fab_bitbang_loader.
interface fab_bitbang_loader_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/fab_bitbang_loader_phase_timer.sv
// Per-phase down-counter: reloaded on every phase change, strobes expire_o in the phase's last cycle.
module fab_bb_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/fab_bitbang_loader.sv
// Streams bitstream words from memory onto the eFPGA s_clk/s_data config port, each data bit paired with a control bit.
// Optional FAB_BB_CHECKSUM_EN adds a running modulo-2^WORD_W sum of all loaded words.
module fab_bitbang_loader
  import fab_bb_pkg::*;
#(
  parameter int          WORD_W    = 32,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] CTRL_WORD = CTRL_WORD_DEFAULT,
  parameter int          PHASE_CYC = 1
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  fab_bitbang_loader_if.master mem,
  output logic              s_clk,
  output logic              s_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_sent
`ifdef FAB_BB_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  localparam int               CNT_W  = $clog2(2 * PHASE_CYC) + 1;
  localparam int               BIT_W  = $clog2(WORD_W);
  localparam logic [WORD_W-1:0] CTRL_W = WORD_W'(CTRL_WORD);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   sent_q, sent_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] ctrl_q, ctrl_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              s_data_q, s_data_d;
  logic              s_clk_q, busy_q, done_q, rd_en_q;
  logic              expire;

  // Every transition starts a new phase, so reloading on any state change keeps the timer aligned.
  fab_bb_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (CLK),
    .rst_n     (resetn),
    .load_i    (state_d != state_q),
    .load_val_i(CNT_W'(phase_len(state_d, PHASE_CYC) - 1)),
    .expire_o  (expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    num_d    = num_q;
    sent_d   = sent_q;
    word_d   = word_q;
    ctrl_d   = ctrl_q;
    bit_d    = bit_q;
    s_data_d = s_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d   = num_words;
          addr_d  = '0;
          sent_d  = '0;
          state_d = (num_words != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        word_d   = mem.rd_data;
        ctrl_d   = CTRL_W;
        bit_d    = BIT_W'(WORD_W - 1);
        s_data_d = mem.rd_data[WORD_W-1];
        state_d  = ST_PH_DATA;
      end
      ST_PH_DATA: if (expire) state_d = ST_PH_RISE;
      ST_PH_RISE: begin
        if (expire) begin
          s_data_d = ctrl_q[WORD_W-1];
          state_d  = ST_PH_CTRL;
        end
      end
      ST_PH_CTRL: if (expire) state_d = ST_PH_FALL;
      ST_PH_FALL: begin
        if (expire) begin
          if (bit_q != '0) begin
            bit_d    = bit_q - 1'b1;
            word_d   = word_q << 1;
            ctrl_d   = ctrl_q << 1;
            s_data_d = word_q[WORD_W-2];
            state_d  = ST_PH_DATA;
          end else begin
            sent_d = sent_q + 1'b1;
            if (sent_d == num_q) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the config pins never glitch on state decode.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      num_q    <= '0;
      sent_q   <= '0;
      word_q   <= '0;
      ctrl_q   <= '0;
      bit_q    <= '0;
      s_data_q <= 1'b0;
      s_clk_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      num_q    <= num_d;
      sent_q   <= sent_d;
      word_q   <= word_d;
      ctrl_q   <= ctrl_d;
      bit_q    <= bit_d;
      s_data_q <= s_data_d;
      s_clk_q  <= (state_d == ST_PH_RISE) || (state_d == ST_PH_CTRL);
      busy_q   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q   <= (state_d == ST_DONE);
      rd_en_q  <= (state_d == ST_FETCH);
    end
  end

`ifdef FAB_BB_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sum_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      sum_q <= '0;
    end else if (state_q == ST_LATCH) begin
      sum_q <= sum_q + mem.rd_data;
    end
  end

  assign checksum = sum_q;
`endif

  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = addr_q;
  assign s_clk       = s_clk_q;
  assign s_data      = s_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign words_sent  = sent_q;

endmodule

// File: tb/tb_fab_bitbang_loader.sv
// Scoreboard bench for fab_bitbang_loader: two instances (PHASE_CYC 1 and 3) driven with random bitstreams.
`timescale 1ns/1ps
module tb_fab_bitbang_loader;

  localparam int          W    = 32;
  localparam int          AW   = 4;
  localparam int          NW   = AW + 1;
  localparam logic [31:0] CTRL = 32'h0000FAB1;

  typedef struct {
    longint      cyc;
    int          words;
    logic [W-1:0] sum;
  } doneExp_t;

  logic   CLK = 1'b0;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     finished [2];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int P        = (g == 0) ? 1 : 3;
    localparam int WORD_CYC = 2 + 5 * P * W;

    logic          resetn;
    logic          start;
    logic [AW:0]   num_words;
    logic          s_clk, s_data, busy, done;
    logic [AW:0]   words_sent;
`ifdef FAB_BB_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif
    logic [W-1:0]  mem [2**AW];

    int       expAddr [$];
    bit       expData [$];
    bit       expCtrl [$];
    doneExp_t expDone [$];
    doneExp_t curDone;
    int       riseCnt;
    int       donesSeen;
    int       doneTarget;
    int       runLen;
    bit       prevClk;

    fab_bitbang_loader_if #(.WORD_W(W), .ADDR_W(AW)) memIf ();

    fab_bitbang_loader #(
      .WORD_W   (W),
      .ADDR_W   (AW),
      .CTRL_WORD(CTRL),
      .PHASE_CYC(P)
    ) u_dut (
      .CLK       (CLK),
      .resetn    (resetn),
      .start     (start),
      .num_words (num_words),
      .mem       (memIf),
      .s_clk     (s_clk),
      .s_data    (s_data),
      .busy      (busy),
      .done      (done),
      .words_sent(words_sent)
`ifdef FAB_BB_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
    );

    // Synchronous memory: data appears the cycle after the read strobe.
    always @(posedge CLK) begin
      if (memIf.rd_en) memIf.rd_data <= mem[memIf.rd_addr];
    end

    // Monitor: pops expectations whenever the DUT shows a read, a serial edge or a done pulse.
    always @(negedge CLK) begin
      if (!resetn) begin
        prevClk = 1'b0;
        runLen  = 0;
      end else begin
        if (memIf.rd_en) begin
          if (expAddr.size() == 0) checkOutput($sformatf("P%0d unexpected rd_en", P), 1, 0);
          else checkOutput($sformatf("P%0d rd_addr", P), 64'(memIf.rd_addr), 64'(expAddr.pop_front()));
        end
        if (s_clk && !prevClk) begin
          if (expData.size() == 0) begin
            checkOutput($sformatf("P%0d unexpected s_clk rise", P), 1, 0);
          end else begin
            checkOutput($sformatf("P%0d data bit %0d", P, riseCnt), 64'(s_data), 64'(expData.pop_front()));
            if (riseCnt % W != 0) checkOutput($sformatf("P%0d s_clk low time", P), 64'(runLen), 64'(3 * P));
          end
          riseCnt++;
          runLen = 0;
        end else if (!s_clk && prevClk) begin
          if (expCtrl.size() == 0) checkOutput($sformatf("P%0d unexpected s_clk fall", P), 1, 0);
          else checkOutput($sformatf("P%0d ctrl bit %0d", P, riseCnt - 1), 64'(s_data), 64'(expCtrl.pop_front()));
          checkOutput($sformatf("P%0d s_clk high time", P), 64'(runLen), 64'(2 * P));
          runLen = 0;
        end
        runLen++;
        if (done) begin
          if (expDone.size() == 0) begin
            checkOutput($sformatf("P%0d unexpected done", P), 1, 0);
          end else begin
            curDone = expDone.pop_front();
            checkOutput($sformatf("P%0d done cycle", P), 64'(cyc), 64'(curDone.cyc));
            checkOutput($sformatf("P%0d words_sent", P), 64'(words_sent), 64'(curDone.words));
            checkOutput($sformatf("P%0d busy at done", P), 64'(busy), 0);
            checkOutput($sformatf("P%0d s_clk rises", P), 64'(riseCnt), 64'(curDone.words * W));
            checkOutput($sformatf("P%0d leftover items", P),
                        64'(expAddr.size() + expData.size() + expCtrl.size()), 0);
`ifdef FAB_BB_CHECKSUM_EN
            checkOutput($sformatf("P%0d checksum", P), 64'(checksum), 64'(curDone.sum));
`endif
          end
          donesSeen++;
        end
        prevClk = s_clk;
      end
    end

    task automatic fillMem();
      for (int k = 0; k < 2**AW; k++) mem[k] = $urandom;
    endtask

    // Reference model: the loader should read words 0..n-1 in order and emit each word's bits
    // MSB-first on rising s_clk and the control word's bits on falling s_clk.
    task automatic applyStimulus(input int n);
      doneExp_t     e;
      logic [W-1:0] sum;
      logic [W-1:0] word;
      logic [W-1:0] ctrlWord;
      ctrlWord = CTRL;
      sum = '0;
      @(negedge CLK);
      for (int k = 0; k < n; k++) begin
        word = mem[k];
        expAddr.push_back(k);
        for (int b = W - 1; b >= 0; b--) begin
          expData.push_back(word[b]);
          expCtrl.push_back(ctrlWord[b]);
        end
        sum = sum + word;
      end
      e.cyc   = cyc + 1 + longint'(n) * WORD_CYC;
      e.words = n;
      e.sum   = sum;
      expDone.push_back(e);
      riseCnt    = 0;
      doneTarget = donesSeen + 1;
      num_words  = NW'(n);
      start      = 1'b1;
      @(negedge CLK);
      start     = 1'b0;
      num_words = NW'($urandom);
    endtask

    task automatic waitDone(input int n);
      int budget;
      budget = n * WORD_CYC + 20;
      while (donesSeen < doneTarget && budget > 0) begin
        @(negedge CLK);
        budget--;
      end
      checkOutput($sformatf("P%0d done within budget", P), 64'(donesSeen >= doneTarget), 1);
      repeat (3) @(negedge CLK);
      checkOutput($sformatf("P%0d words_sent hold", P), 64'(words_sent), 64'(n));
      checkOutput($sformatf("P%0d idle busy", P), 64'(busy), 0);
      checkOutput($sformatf("P%0d idle s_clk", P), 64'(s_clk), 0);
    endtask

    initial begin
      int n;
      int budget;
      finished[g] = 1'b0;
      resetn      = 1'b0;
      start       = 1'b0;
      num_words   = '0;
      donesSeen   = 0;
      doneTarget  = 0;
      riseCnt     = 0;
      fillMem();
      repeat (3) @(negedge CLK);
      checkOutput($sformatf("P%0d reset outputs", P),
                  64'({s_clk, s_data, busy, done, memIf.rd_en, memIf.rd_addr, words_sent}), 0);
      resetn = 1'b1;

      // Directed first load: one marker word at P=1, words 1..4 at P=3.
      if (P == 1) begin
        mem[0] = 32'hA5A5_0001;
        n = 1;
      end else begin
        for (int k = 0; k < 4; k++) mem[k] = W'(k + 1);
        n = 4;
      end
      $display("[TB] P=%0d directed load of %0d words", P, n);
      applyStimulus(n);
      waitDone(n);

      applyStimulus(0);
      waitDone(0);

      repeat (3) begin
        fillMem();
        n = $urandom_range(1, 3);
        applyStimulus(n);
        waitDone(n);
      end

      // A second start partway through word 1 must be ignored.
      fillMem();
      applyStimulus(2);
      repeat (WORD_CYC + 40 * P) @(negedge CLK);
      checkOutput($sformatf("P%0d busy mid-load", P), 64'(busy), 1);
      start     = 1'b1;
      num_words = NW'(5);
      @(negedge CLK);
      start = 1'b0;
      waitDone(2);

      // Async reset while s_clk is high for word 1, bit 7 (57th rising edge of the load).
      fillMem();
      applyStimulus(3);
      budget = 3 * WORD_CYC;
      while (riseCnt < 57 && budget > 0) begin
        @(negedge CLK);
        #1;
        budget--;
      end
      checkOutput($sformatf("P%0d reached word1 bit7", P), 64'(riseCnt), 57);
      checkOutput($sformatf("P%0d s_clk high before reset", P), 64'(s_clk), 1);
      #1 resetn = 1'b0;
      #1;
      checkOutput($sformatf("P%0d async reset outputs", P),
                  64'({s_clk, s_data, busy, done, words_sent}), 0);
      expAddr.delete();
      expData.delete();
      expCtrl.delete();
      expDone.delete();
      riseCnt = 0;
      repeat (2) @(negedge CLK);
      resetn = 1'b1;
      fillMem();
      applyStimulus(2);
      waitDone(2);

      // Full-depth load: address space wraps only after the last word.
      fillMem();
      applyStimulus(2**AW);
      waitDone(2**AW);

      finished[g] = 1'b1;
    end
  end

  initial begin
    int budget;
    budget = 60000;
    while (!(finished[0] && finished[1]) && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    checkOutput("all scenarios completed", 64'({finished[0], finished[1]}), 64'(2'b11));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
